regfile_mp: RTL and testbench

Multi-issue, multi-commit rename register file between issue stage and ROB.
- Holds architectural values `v[]` and ROB-tag bindings `q[]`.
- Each cycle it renames up to ISSUE_W instructions, resolving source tags and values, including dependencies inside the same issue bundle.
- It retires up to COMMIT_W ROB results and clears a binding only when the committing tag still owns the register.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_src_resolve.sv | 59 +++++
 rtl/regfile_mp.sv | 155 +++++++++++++++
 tb/tb_regfile_mp.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and issue-payload layout for the rename register file.
// The commit bypass is enabled by defining REGFILE_CM_BYPASS_EN.
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int ROB_AW_DEF = 4;
    localparam int RAW_DEF    = 5;
    localparam int INS_OP_W   = 7;

    // Tag 0 marks "no producer in flight, value in v[] is current".
    localparam int ROB_TAG_NONE = 0;

    typedef struct packed {
        logic [INS_OP_W-1:0] op;
        logic [XLEN_DEF-1:0] imm;
        logic [XLEN_DEF-1:0] pc;
        logic                ils;
    } pass_t;

    localparam int PW = $bits(pass_t);

endpackage

// File: rtl/regfile_src_resolve.sv
// Combinational source-operand resolution for one issue slot/source.
// The commit bypass stage exists only when REGFILE_CM_BYPASS_EN is defined.
module regfile_src_resolve
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int RAW      = RAW_DEF,
    parameter int ROB_AW   = ROB_AW_DEF,
    parameter int ISSUE_W  = 2,
    parameter int COMMIT_W = 2,
    parameter int SLOT     = 0
) (
    input  logic [RAW-1:0]             rs_i,
    input  logic [ISSUE_W-1:0]         is_en_i,
    input  logic [ISSUE_W*RAW-1:0]     is_rd_i,
    input  logic [ISSUE_W*ROB_AW-1:0]  qn_i,
    input  logic [COMMIT_W-1:0]        cm_en_i,
    input  logic [COMMIT_W*RAW-1:0]    cm_rd_i,
    input  logic [COMMIT_W*ROB_AW-1:0] cm_tag_i,
    input  logic [COMMIT_W*XLEN-1:0]   cm_vd_i,
    input  logic [ROB_AW-1:0]          q_rs_i,
    input  logic [XLEN-1:0]            v_rs_i,
    output logic [ROB_AW-1:0]          q_o,
    output logic [XLEN-1:0]            v_o
);

`ifndef REGFILE_CM_BYPASS_EN
    logic unused_cm;
    assign unused_cm = ^{cm_en_i, cm_rd_i, cm_tag_i, cm_vd_i};
`endif

    // Stages are applied lowest priority first so later overwrites win.
    always_comb begin
        q_o = q_rs_i;
        v_o = v_rs_i;
`ifdef REGFILE_CM_BYPASS_EN
        for (int c = 0; c < COMMIT_W; c++) begin
            if (cm_en_i[c] && cm_rd_i[c*RAW +: RAW] == rs_i
                    && cm_tag_i[c*ROB_AW +: ROB_AW] == q_rs_i) begin
                q_o = ROB_AW'(ROB_TAG_NONE);
                v_o = cm_vd_i[c*XLEN +: XLEN];
            end
        end
`endif
        // Older slots in the same bundle; the youngest one is visited last.
        for (int j = 0; j < ISSUE_W; j++) begin
            if (j < SLOT && is_en_i[j] && is_rd_i[j*RAW +: RAW] == rs_i
                    && is_rd_i[j*RAW +: RAW] != '0) begin
                q_o = qn_i[j*ROB_AW +: ROB_AW];
                v_o = '0;
            end
        end
        if (rs_i == '0) begin
            q_o = ROB_AW'(ROB_TAG_NONE);
            v_o = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-issue / multi-commit rename register file holding values and ROB tags.
// Define REGFILE_CM_BYPASS_EN to forward same-cycle commits to issuing sources.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = 32,
    parameter int ROB_AW   = ROB_AW_DEF,
    parameter int ISSUE_W  = 2,
    parameter int COMMIT_W = 2,
    localparam int RAW     = $clog2(NREG)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [ISSUE_W-1:0]         iIS_En,
    input  logic [ISSUE_W*RAW-1:0]     iIS_Rs1,
    input  logic [ISSUE_W*RAW-1:0]     iIS_Rs2,
    input  logic [ISSUE_W*RAW-1:0]     iIS_Rd,
    input  logic [ISSUE_W*PW-1:0]      iIS_Pass,
    input  logic [ISSUE_W*ROB_AW-1:0]  iROB_Qn,
    input  logic [COMMIT_W-1:0]        iCM_En,
    input  logic [COMMIT_W*RAW-1:0]    iCM_Rd,
    input  logic [COMMIT_W*ROB_AW-1:0] iCM_Tag,
    input  logic [COMMIT_W*XLEN-1:0]   iCM_Vd,
    input  logic                       iROB_Mp,
    output logic [ISSUE_W-1:0]         oROB_En,
    output logic [ISSUE_W*ROB_AW-1:0]  oROB_Qs1,
    output logic [ISSUE_W*ROB_AW-1:0]  oROB_Qs2,
    output logic [ISSUE_W*ROB_AW-1:0]  oROB_Qd,
    output logic [ISSUE_W*XLEN-1:0]    oROB_Vs1,
    output logic [ISSUE_W*XLEN-1:0]    oROB_Vs2,
    output logic [ISSUE_W*PW-1:0]      oROB_Pass
);

    logic [XLEN-1:0]   v_q [NREG];
    logic [XLEN-1:0]   v_d [NREG];
    logic [ROB_AW-1:0] q_q [NREG];
    logic [ROB_AW-1:0] q_d [NREG];

    logic [ISSUE_W-1:0]        en_q, en_d;
    logic [ISSUE_W*ROB_AW-1:0] qs1_q, qs1_d, qs2_q, qs2_d, qd_q, qd_d;
    logic [ISSUE_W*XLEN-1:0]   vs1_q, vs1_d, vs2_q, vs2_d;
    logic [ISSUE_W*PW-1:0]     pass_q, pass_d;
    logic                      upd;

    // A flush must take effect even while the pipeline is stalled.
    assign upd = en | iROB_Mp;

    genvar gi;
    generate
        for (gi = 0; gi < ISSUE_W; gi++) begin : g_slot
            logic [RAW-1:0]    rs1, rs2;
            logic [ROB_AW-1:0] r_q1, r_q2;
            logic [XLEN-1:0]   r_v1, r_v2;
            logic              slot_ok;

            assign rs1     = iIS_Rs1[gi*RAW +: RAW];
            assign rs2     = iIS_Rs2[gi*RAW +: RAW];
            assign slot_ok = iIS_En[gi] & ~iROB_Mp;

            regfile_src_resolve #(
                .XLEN(XLEN), .RAW(RAW), .ROB_AW(ROB_AW),
                .ISSUE_W(ISSUE_W), .COMMIT_W(COMMIT_W), .SLOT(gi)
            ) u_rs1 (
                .rs_i(rs1), .is_en_i(iIS_En), .is_rd_i(iIS_Rd), .qn_i(iROB_Qn),
                .cm_en_i(iCM_En), .cm_rd_i(iCM_Rd), .cm_tag_i(iCM_Tag), .cm_vd_i(iCM_Vd),
                .q_rs_i(q_q[rs1]), .v_rs_i(v_q[rs1]), .q_o(r_q1), .v_o(r_v1)
            );

            regfile_src_resolve #(
                .XLEN(XLEN), .RAW(RAW), .ROB_AW(ROB_AW),
                .ISSUE_W(ISSUE_W), .COMMIT_W(COMMIT_W), .SLOT(gi)
            ) u_rs2 (
                .rs_i(rs2), .is_en_i(iIS_En), .is_rd_i(iIS_Rd), .qn_i(iROB_Qn),
                .cm_en_i(iCM_En), .cm_rd_i(iCM_Rd), .cm_tag_i(iCM_Tag), .cm_vd_i(iCM_Vd),
                .q_rs_i(q_q[rs2]), .v_rs_i(v_q[rs2]), .q_o(r_q2), .v_o(r_v2)
            );

            assign en_d[gi]                      = slot_ok;
            assign qs1_d[gi*ROB_AW +: ROB_AW]    = slot_ok ? r_q1 : '0;
            assign qs2_d[gi*ROB_AW +: ROB_AW]    = slot_ok ? r_q2 : '0;
            assign vs1_d[gi*XLEN +: XLEN]        = slot_ok ? r_v1 : '0;
            assign vs2_d[gi*XLEN +: XLEN]        = slot_ok ? r_v2 : '0;
            assign qd_d[gi*ROB_AW +: ROB_AW]     = slot_ok ? iROB_Qn[gi*ROB_AW +: ROB_AW] : '0;
            assign pass_d[gi*PW +: PW]           = slot_ok ? iIS_Pass[gi*PW +: PW] : '0;
        end
    endgenerate

    // Commit clears compare against pre-cycle q; renames are applied last so they win.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            v_d[r] = v_q[r];
            q_d[r] = q_q[r];
        end
        for (int c = 0; c < COMMIT_W; c++) begin
            if (iCM_En[c] && iCM_Rd[c*RAW +: RAW] != '0) begin
                v_d[iCM_Rd[c*RAW +: RAW]] = iCM_Vd[c*XLEN +: XLEN];
                if (q_q[iCM_Rd[c*RAW +: RAW]] == iCM_Tag[c*ROB_AW +: ROB_AW]) begin
                    q_d[iCM_Rd[c*RAW +: RAW]] = ROB_AW'(ROB_TAG_NONE);
                end
            end
        end
        if (iROB_Mp) begin
            for (int r = 0; r < NREG; r++) begin
                q_d[r] = ROB_AW'(ROB_TAG_NONE);
            end
        end else begin
            for (int k = 0; k < ISSUE_W; k++) begin
                if (iIS_En[k] && iIS_Rd[k*RAW +: RAW] != '0) begin
                    q_d[iIS_Rd[k*RAW +: RAW]] = iROB_Qn[k*ROB_AW +: ROB_AW];
                end
            end
        end
        v_d[0] = '0;
        q_d[0] = ROB_AW'(ROB_TAG_NONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                v_q[r] <= '0;
                q_q[r] <= '0;
            end
            en_q   <= '0;
            qs1_q  <= '0;
            qs2_q  <= '0;
            qd_q   <= '0;
            vs1_q  <= '0;
            vs2_q  <= '0;
            pass_q <= '0;
        end else if (upd) begin
            for (int r = 0; r < NREG; r++) begin
                v_q[r] <= v_d[r];
                q_q[r] <= q_d[r];
            end
            en_q   <= en_d;
            qs1_q  <= qs1_d;
            qs2_q  <= qs2_d;
            qd_q   <= qd_d;
            vs1_q  <= vs1_d;
            vs2_q  <= vs2_d;
            pass_q <= pass_d;
        end
    end

    assign oROB_En   = en_q;
    assign oROB_Qs1  = qs1_q;
    assign oROB_Qs2  = qs2_q;
    assign oROB_Qd   = qd_q;
    assign oROB_Vs1  = vs1_q;
    assign oROB_Vs2  = vs2_q;
    assign oROB_Pass = pass_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default two issue / two commit slots).
// Expectations for the same-cycle commit case follow REGFILE_CM_BYPASS_EN.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int XL = XLEN_DEF;
    localparam int RA = RAW_DEF;
    localparam int TA = ROB_AW_DEF;
    localparam int IW = 2;
    localparam int CW = 2;

    typedef logic [127:0] w_t;

    logic            clk = 1'b0;
    logic            rst, en;
    logic [IW-1:0]   iIS_En;
    logic [IW*RA-1:0] iIS_Rs1, iIS_Rs2, iIS_Rd;
    logic [IW*PW-1:0] iIS_Pass;
    logic [IW*TA-1:0] iROB_Qn;
    logic [CW-1:0]   iCM_En;
    logic [CW*RA-1:0] iCM_Rd;
    logic [CW*TA-1:0] iCM_Tag;
    logic [CW*XL-1:0] iCM_Vd;
    logic            iROB_Mp;
    logic [IW-1:0]   oROB_En;
    logic [IW*TA-1:0] oROB_Qs1, oROB_Qs2, oROB_Qd;
    logic [IW*XL-1:0] oROB_Vs1, oROB_Vs2;
    logic [IW*PW-1:0] oROB_Pass;

    int n_assert = 0;
    int n_fail   = 0;

    regfile_mp dut (
        .clk(clk), .rst(rst), .en(en),
        .iIS_En(iIS_En), .iIS_Rs1(iIS_Rs1), .iIS_Rs2(iIS_Rs2), .iIS_Rd(iIS_Rd),
        .iIS_Pass(iIS_Pass), .iROB_Qn(iROB_Qn),
        .iCM_En(iCM_En), .iCM_Rd(iCM_Rd), .iCM_Tag(iCM_Tag), .iCM_Vd(iCM_Vd),
        .iROB_Mp(iROB_Mp),
        .oROB_En(oROB_En), .oROB_Qs1(oROB_Qs1), .oROB_Qs2(oROB_Qs2), .oROB_Qd(oROB_Qd),
        .oROB_Vs1(oROB_Vs1), .oROB_Vs2(oROB_Vs2), .oROB_Pass(oROB_Pass)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-12s observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic w_t sl(input w_t vec, input int k, input int w);
        w_t m;
        m = (w_t'(1) << w) - w_t'(1);
        return (vec >> (k * w)) & m;
    endfunction

    task automatic idle();
        iIS_En = '0; iIS_Rs1 = '0; iIS_Rs2 = '0; iIS_Rd = '0;
        iIS_Pass = '0; iROB_Qn = '0;
        iCM_En = '0; iCM_Rd = '0; iCM_Tag = '0; iCM_Vd = '0;
        iROB_Mp = 1'b0;
    endtask

    task automatic issue(input int k, input int rs1, input int rs2, input int rd,
                         input int qn, input int pass);
        iIS_En[k]              = 1'b1;
        iIS_Rs1[k*RA +: RA]    = RA'(rs1);
        iIS_Rs2[k*RA +: RA]    = RA'(rs2);
        iIS_Rd[k*RA +: RA]     = RA'(rd);
        iROB_Qn[k*TA +: TA]    = TA'(qn);
        iIS_Pass[k*PW +: PW]   = PW'(pass);
    endtask

    task automatic commit(input int c, input int rd, input int tag, input int vd);
        iCM_En[c]             = 1'b1;
        iCM_Rd[c*RA +: RA]    = RA'(rd);
        iCM_Tag[c*TA +: TA]   = TA'(tag);
        iCM_Vd[c*XL +: XL]    = XL'(vd);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; idle();
        tick(); tick();
        rst = 1'b0;

        // Write x5, then reset and confirm everything is cleared.
        commit(0, 5, 1, 'h77); tick(); idle();
        issue(0, 5, 0, 0, 1, 'h11); tick(); idle();
        chk("pre_rst_vs1", sl(w_t'(oROB_Vs1), 0, XL), w_t'('h77));
        chk("pass0",       sl(w_t'(oROB_Pass), 0, PW), w_t'('h11));
        chk("pass1_inv",   sl(w_t'(oROB_Pass), 1, PW), w_t'(0));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_en",   w_t'(oROB_En),   w_t'(0));
        chk("rst_vs1",  w_t'(oROB_Vs1),  w_t'(0));
        chk("rst_pass", w_t'(oROB_Pass), w_t'(0));
        chk("rst_qd",   w_t'(oROB_Qd),   w_t'(0));
        issue(0, 5, 0, 0, 1, 0); tick(); idle();
        chk("x5_qs1", sl(w_t'(oROB_Qs1), 0, TA), w_t'(0));
        chk("x5_vs1", sl(w_t'(oROB_Vs1), 0, XL), w_t'(0));

        // In-bundle dependency; both slots rename x3, slot 1 wins.
        issue(0, 0, 0, 3, 7, 0); issue(1, 3, 0, 3, 8, 0); tick(); idle();
        chk("bun_en",  w_t'(oROB_En), w_t'(2'b11));
        chk("bun_qs1", sl(w_t'(oROB_Qs1), 1, TA), w_t'(7));
        chk("bun_qs2", sl(w_t'(oROB_Qs2), 1, TA), w_t'(0));
        chk("bun_qd0", sl(w_t'(oROB_Qd), 0, TA), w_t'(7));
        chk("bun_qd1", sl(w_t'(oROB_Qd), 1, TA), w_t'(8));
        issue(0, 3, 3, 0, 1, 0); tick(); idle();
        chk("q3_is_8", sl(w_t'(oROB_Qs1), 0, TA), w_t'(8));

        // Commit of x4 in the same cycle it is read.
        issue(0, 0, 0, 4, 5, 0); tick(); idle();
        commit(0, 4, 5, 'hAB); issue(0, 4, 0, 0, 1, 0); tick(); idle();
`ifdef REGFILE_CM_BYPASS_EN
        chk("byp_qs1", sl(w_t'(oROB_Qs1), 0, TA), w_t'(0));
        chk("byp_vs1", sl(w_t'(oROB_Vs1), 0, XL), w_t'('hAB));
`else
        chk("byp_qs1", sl(w_t'(oROB_Qs1), 0, TA), w_t'(5));
        chk("byp_vs1", sl(w_t'(oROB_Vs1), 0, XL), w_t'(0));
`endif
        issue(0, 4, 0, 0, 1, 0); tick(); idle();
        chk("x4_qs1", sl(w_t'(oROB_Qs1), 0, TA), w_t'(0));
        chk("x4_vs1", sl(w_t'(oROB_Vs1), 0, XL), w_t'('hAB));

        // Stale-tag commit keeps the binding; rename beats the matching clear.
        issue(0, 0, 0, 6, 9, 0); tick(); idle();
        commit(0, 6, 2, 1); tick(); idle();
        issue(0, 6, 0, 0, 1, 0); tick(); idle();
        chk("x6_qs1", sl(w_t'(oROB_Qs1), 0, TA), w_t'(9));
        chk("x6_vs1", sl(w_t'(oROB_Vs1), 0, XL), w_t'(1));
        commit(0, 6, 9, 2); issue(0, 0, 0, 6, 10, 0); tick(); idle();
        issue(0, 6, 0, 0, 1, 0); tick(); idle();
        chk("x6_ren_qs1", sl(w_t'(oROB_Qs1), 0, TA), w_t'(10));
        chk("x6_ren_vs1", sl(w_t'(oROB_Vs1), 0, XL), w_t'(2));

        // Two commits to the same register: the higher slot's value lands.
        commit(0, 7, 1, 'h10); commit(1, 7, 1, 'h20); tick(); idle();
        issue(1, 0, 7, 0, 1, 0); tick(); idle();
        chk("x7_vs2", sl(w_t'(oROB_Vs2), 1, XL), w_t'('h20));

        // Flush: bindings dropped, same-cycle commit still lands, issue dropped.
        issue(0, 0, 0, 1, 3, 0); tick(); idle();
        iROB_Mp = 1'b1; commit(0, 2, 1, 'h55); issue(0, 1, 0, 12, 4, 'h3); tick(); idle();
        chk("mp_en",   w_t'(oROB_En),   w_t'(0));
        chk("mp_qd",   w_t'(oROB_Qd),   w_t'(0));
        chk("mp_pass", w_t'(oROB_Pass), w_t'(0));
        issue(0, 2, 1, 0, 1, 0); issue(1, 6, 3, 0, 2, 0); tick(); idle();
        chk("mp_v2",   sl(w_t'(oROB_Vs1), 0, XL), w_t'('h55));
        chk("mp_q1",   sl(w_t'(oROB_Qs2), 0, TA), w_t'(0));
        chk("mp_q6",   sl(w_t'(oROB_Qs1), 1, TA), w_t'(0));
        chk("mp_v6",   sl(w_t'(oROB_Vs1), 1, XL), w_t'(2));
        chk("mp_q3",   sl(w_t'(oROB_Qs2), 1, TA), w_t'(0));

        // Stall for three cycles with issue and commit traffic present.
        issue(0, 6, 0, 11, 12, 'h5); tick(); idle();
        en = 1'b0;
        issue(0, 6, 0, 6, 13, 'h6); issue(1, 2, 0, 2, 14, 'h7); commit(0, 6, 0, 'h99);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_en",   w_t'(oROB_En), w_t'(2'b01));
            chk("stall_qd",   sl(w_t'(oROB_Qd), 0, TA), w_t'(12));
            chk("stall_vs1",  sl(w_t'(oROB_Vs1), 0, XL), w_t'(2));
            chk("stall_pass", sl(w_t'(oROB_Pass), 0, PW), w_t'('h5));
        end
        en = 1'b1; idle();
        issue(0, 6, 11, 0, 1, 0); issue(1, 2, 0, 0, 2, 0); tick(); idle();
        chk("post_q6",  sl(w_t'(oROB_Qs1), 0, TA), w_t'(0));
        chk("post_v6",  sl(w_t'(oROB_Vs1), 0, XL), w_t'(2));
        chk("post_q11", sl(w_t'(oROB_Qs2), 0, TA), w_t'(12));
        chk("post_q2",  sl(w_t'(oROB_Qs1), 1, TA), w_t'(0));

        // x0 ignores rename and commit; rd=0 never forwards in-bundle.
        issue(0, 0, 0, 0, 5, 0); issue(1, 0, 0, 0, 6, 0); commit(0, 0, 0, 'hFF); tick(); idle();
        chk("x0_fwd_q", sl(w_t'(oROB_Qs1), 1, TA), w_t'(0));
        issue(0, 0, 0, 0, 1, 0); tick(); idle();
        chk("x0_qs1", sl(w_t'(oROB_Qs1), 0, TA), w_t'(0));
        chk("x0_vs1", sl(w_t'(oROB_Vs1), 0, XL), w_t'(0));
        chk("x0_vs2", sl(w_t'(oROB_Vs2), 0, XL), w_t'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
